// File: rtl/pipe_hazard_ctrl_if.sv
// Control/status bundle between the 3-stage pipeline datapath (master) and
// its stall/flush/forwarding controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_DE;
    logic [4:0]       rs2_DE;
    logic             rs1_used_DE;
    logic             rs2_used_DE;
    logic             br_taken_DE;
    logic [4:0]       rd_MW;
    logic             reg_wrMW;
    logic             rd_enMW;
    logic             wr_enMW;
    logic             dmem_ack;
    logic             en_pc;
    logic             en_FD;
    logic             en_MW;
    logic             flush_FD;
    logic             flush_MW;
    logic             fwd_a;
    logic             fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs1_DE, rs2_DE, rs1_used_DE, rs2_used_DE, br_taken_DE,
        output rd_MW, reg_wrMW, rd_enMW, wr_enMW, dmem_ack,
        input  en_pc, en_FD, en_MW, flush_FD, flush_MW,
        input  fwd_a, fwd_b, mem_err, stall_cnt
    );

    modport slave (
        input  rs1_DE, rs2_DE, rs1_used_DE, rs2_used_DE, br_taken_DE,
        input  rd_MW, reg_wrMW, rd_enMW, wr_enMW, dmem_ack,
        output en_pc, en_FD, en_MW, flush_FD, flush_MW,
        output fwd_a, fwd_b, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding controller for the IF -> DE -> MW pipeline,
// including data-memory wait handling with timeout and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int                WCNT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_LD_STALL = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic mem_req_s;
    logic hit1_s;
    logic hit2_s;
    logic ld_use_s;
    logic fwd_a_s;
    logic fwd_b_s;
    logic use_run_s;
    logic en_pc_s;
    logic en_fd_s;
    logic en_mw_s;
    logic flush_fd_s;
    logic flush_mw_s;
    logic mem_err_s;

    // x0 is hard-wired zero, so a match on it is never a real dependency
    function automatic logic src_hit(input logic       used,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
        return used && (rs == rd) && (rd != 5'd0);
    endfunction

    assign mem_req_s = hz.rd_enMW | hz.wr_enMW;
    assign hit1_s    = src_hit(hz.rs1_used_DE, hz.rs1_DE, hz.rd_MW);
    assign hit2_s    = src_hit(hz.rs2_used_DE, hz.rs2_DE, hz.rd_MW);
    assign ld_use_s  = hz.rd_enMW & hz.reg_wrMW & (hit1_s | hit2_s);
    assign fwd_a_s   = hz.reg_wrMW & ~hz.rd_enMW & hit1_s;
    assign fwd_b_s   = hz.reg_wrMW & ~hz.rd_enMW & hit2_s;

    // Next-state and pipeline-control decode from the current state and DE/MW status
    always_comb begin
        en_pc_s     = 1'b1;
        en_fd_s     = 1'b1;
        en_mw_s     = 1'b1;
        flush_fd_s  = 1'b0;
        flush_mw_s  = 1'b0;
        mem_err_s   = 1'b0;
        use_run_s   = 1'b0;
        state_nxt_s = ST_RUN;
        wcnt_nxt_s  = WCNT_ZERO;
        case (state_r)
            ST_RUN, ST_LD_STALL: begin
                if (mem_req_s && !hz.dmem_ack) begin
                    en_pc_s     = 1'b0;
                    en_fd_s     = 1'b0;
                    en_mw_s     = 1'b0;
                    state_nxt_s = ST_MEM_WAIT;
                    wcnt_nxt_s  = WCNT_ONE;
                end else begin
                    use_run_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ack) begin
                    use_run_s = 1'b1;
                end else if (wcnt_r >= WAIT_LIM) begin
                    // abandon the access and let the pipeline move on
                    mem_err_s = 1'b1;
                end else begin
                    en_pc_s     = 1'b0;
                    en_fd_s     = 1'b0;
                    en_mw_s     = 1'b0;
                    state_nxt_s = ST_MEM_WAIT;
                    wcnt_nxt_s  = wcnt_r + WCNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase

        // load-use beats a taken branch; the branch is re-seen after the stall
        if (use_run_s) begin
            if (ld_use_s) begin
                en_pc_s     = 1'b0;
                en_fd_s     = 1'b0;
                flush_mw_s  = 1'b1;
                state_nxt_s = ST_LD_STALL;
            end else if (hz.br_taken_DE) begin
                flush_fd_s = 1'b1;
            end else begin
                flush_fd_s = 1'b0;
            end
        end else begin
            flush_mw_s = 1'b0;
        end
    end

    // FSM state and memory-wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            wcnt_r  <= WCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (!en_pc_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // a flush only takes effect on a buffer that is actually loading
    assign hz.en_pc     = rst & en_pc_s;
    assign hz.en_FD     = rst & en_fd_s;
    assign hz.en_MW     = rst & en_mw_s;
    assign hz.flush_FD  = rst & en_fd_s & flush_fd_s;
    assign hz.flush_MW  = rst & en_mw_s & flush_mw_s;
    assign hz.fwd_a     = rst & fwd_a_s;
    assign hz.fwd_b     = rst & fwd_b_s;
    assign hz.mem_err   = rst & mem_err_s;
    assign hz.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, multi-cycle
// sequences and randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int   WAIT_MAX = 15;
    localparam int   SAT_W    = 4;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32))    hz();
    pipe_hazard_ctrl_if #(.CNT_W(SAT_W)) hz_s();

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hz(hz)
    );
    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .hz(hz_s)
    );

    assign hz_s.rs1_DE      = hz.rs1_DE;
    assign hz_s.rs2_DE      = hz.rs2_DE;
    assign hz_s.rs1_used_DE = hz.rs1_used_DE;
    assign hz_s.rs2_used_DE = hz.rs2_used_DE;
    assign hz_s.br_taken_DE = hz.br_taken_DE;
    assign hz_s.rd_MW       = hz.rd_MW;
    assign hz_s.reg_wrMW    = hz.reg_wrMW;
    assign hz_s.rd_enMW     = hz.rd_enMW;
    assign hz_s.wr_enMW     = hz.wr_enMW;
    assign hz_s.dmem_ack    = hz.dmem_ack;

    // exp bit order: en_pc en_FD en_MW flush_FD flush_MW fwd_a fwd_b mem_err
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       st;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          m_age    = 0;
    longint      m_cnt    = 0;
    logic [7:0]  last_out;
    vec_t        tbl[16];
    vec_t        idle;

    function automatic vec_t mkv(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                 logic br, logic [4:0] rd, logic wr, logic ld,
                                 logic st, logic ack, logic [7:0] e);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br;
        v.rd = rd; v.wr = wr; v.ld = ld; v.st = st; v.ack = ack; v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] dut_out();
        return {hz.en_pc, hz.en_FD, hz.en_MW, hz.flush_FD, hz.flush_MW,
                hz.fwd_a, hz.fwd_b, hz.mem_err};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.rs1_DE = v.rs1; hz.rs2_DE = v.rs2;
        hz.rs1_used_DE = v.u1; hz.rs2_used_DE = v.u2;
        hz.br_taken_DE = v.br; hz.rd_MW = v.rd; hz.reg_wrMW = v.wr;
        hz.rd_enMW = v.ld; hz.wr_enMW = v.st; hz.dmem_ack = v.ack;
    endtask

    // Reference: m_age = cycles already spent waiting on memory (0 = none pending)
    task automatic model_step(input vec_t v, output logic [7:0] e);
        logic h1, h2, ld_use, mreq, pc, fd, mw, ffd, fmw, err;
        int   nage;
        h1     = v.u1 && (v.rs1 == v.rd) && (v.rd != 5'd0);
        h2     = v.u2 && (v.rs2 == v.rd) && (v.rd != 5'd0);
        ld_use = v.ld && v.wr && (h1 || h2);
        mreq   = v.ld || v.st;
        pc = I; fd = I; mw = I; ffd = O; fmw = O; err = O; nage = 0;
        if (m_age > 0 && !v.ack) begin
            if (m_age >= WAIT_MAX) err = I;
            else begin pc = O; fd = O; mw = O; nage = m_age + 1; end
        end else if (m_age == 0 && mreq && !v.ack) begin
            pc = O; fd = O; mw = O; nage = 1;
        end else if (ld_use) begin
            pc = O; fd = O; fmw = I;
        end else if (v.br) begin
            ffd = I;
        end
        e = {pc, fd, mw, ffd, fmw, v.wr && !v.ld && h1, v.wr && !v.ld && h2, err};
        m_age = nage;
        if (!pc) m_cnt++;
    endtask

    // Called at posedge+1; compares at the following negedge, returns at next posedge+1
    task automatic run_cycle(input vec_t v, input logic use_tbl, input string name);
        logic [7:0] e;
        drive(v);
        @(negedge clk);
        check("stall_cnt", hz.stall_cnt, m_cnt[31:0]);
        check("stall_cnt_sat", {28'd0, hz_s.stall_cnt}, (m_cnt > 15) ? 32'd15 : m_cnt[31:0]);
        model_step(v, e);
        last_out = dut_out();
        check(name, {24'd0, last_out}, {24'd0, (use_tbl ? v.exp : e)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        vec_t st_noack;
        vec_t st_ack;
        int   stalls;
        int   err_at;
        logic err_seen;
        logic [3:0]  fl;
        logic [31:0] c0;

        idle     = mkv(5'd0, 5'd0, O, O, O, 5'd0, O, O, O, O, 8'b1110_0000);
        st_noack = mkv(5'd0, 5'd0, O, O, O, 5'd0, O, O, I, O, 8'h00);
        st_ack   = mkv(5'd0, 5'd0, O, O, O, 5'd0, O, O, I, I, 8'b1110_0000);

        tbl[0]  = mkv(5'd5, 5'd5, I, O, O, 5'd5, I, O, O, O, 8'b1110_0100);
        tbl[1]  = mkv(5'd0, 5'd5, I, O, O, 5'd0, I, O, O, O, 8'b1110_0000);
        tbl[2]  = mkv(5'd3, 5'd9, I, I, O, 5'd9, I, O, O, O, 8'b1110_0010);
        tbl[3]  = mkv(5'd4, 5'd4, I, I, O, 5'd4, I, O, O, O, 8'b1110_0110);
        tbl[4]  = mkv(5'd4, 5'd4, O, O, O, 5'd4, I, O, O, O, 8'b1110_0000);
        tbl[5]  = mkv(5'd0, 5'd7, O, I, O, 5'd7, I, I, O, I, 8'b0010_1000);
        tbl[6]  = idle;
        tbl[7]  = mkv(5'd0, 5'd0, I, O, O, 5'd0, I, I, O, I, 8'b1110_0000);
        tbl[8]  = mkv(5'd6, 5'd0, I, O, O, 5'd6, O, O, I, I, 8'b1110_0000);
        tbl[9]  = mkv(5'd0, 5'd0, O, O, I, 5'd0, O, O, O, O, 8'b1111_0000);
        tbl[10] = mkv(5'd8, 5'd0, I, O, I, 5'd8, I, I, O, I, 8'b0010_1000);
        tbl[11] = mkv(5'd0, 5'd0, O, O, I, 5'd0, O, O, O, O, 8'b1111_0000);
        tbl[12] = mkv(5'd4, 5'd0, I, O, O, 5'd3, I, I, O, I, 8'b1110_0000);
        tbl[13] = mkv(5'd0, 5'd7, O, I, O, 5'd7, I, I, O, O, 8'b0000_0000);
        tbl[14] = mkv(5'd0, 5'd7, O, I, O, 5'd7, I, I, O, I, 8'b0010_1000);
        tbl[15] = idle;

        // Reset state with hazard-provoking inputs: everything must be forced low
        rst = 1'b0;
        drive(mkv(5'd5, 5'd5, I, I, I, 5'd5, I, O, O, O, 8'h00));
        #2;
        check("reset_outs", {24'd0, dut_out()}, 32'd0);
        check("reset_cnt", hz.stall_cnt, 32'd0);
        drive(idle);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) run_cycle(tbl[i], I, $sformatf("tbl%0d", i));

        // Memory wait: 3 stalled cycles, release on ack, no error
        c0 = hz.stall_cnt;
        err_seen = O;
        for (int k = 0; k < 3; k++) begin
            run_cycle(st_noack, O, "memwait");
            err_seen = err_seen | last_out[0];
        end
        run_cycle(st_ack, O, "memwait_ack");
        err_seen = err_seen | last_out[0];
        check("memwait_ack_en", {29'd0, last_out[7:5]}, 32'd7);
        check("memwait_delta", hz.stall_cnt - c0, 32'd3);
        check("memwait_no_err", {31'd0, err_seen}, 32'd0);

        // Timeout: load never acknowledged
        v = mkv(5'd0, 5'd0, O, O, O, 5'd0, O, I, O, O, 8'h00);
        stalls = 0;
        err_at = -1;
        for (int k = 0; k < 16; k++) begin
            run_cycle(v, O, "timeout");
            if (err_at < 0 && !last_out[7]) stalls++;
            if (err_at < 0 && last_out[0]) err_at = k;
        end
        check("timeout_stalls", stalls, 32'd15);
        check("timeout_err_cycle", err_at, 32'd15);
        check("timeout_err_en", {29'd0, last_out[7:5]}, 32'd7);
        run_cycle(idle, I, "after_timeout");

        // Branch held in DE while memory waits: flush only on the ack cycle
        v = st_noack; v.br = I;
        fl = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) v.ack = I;
            run_cycle(v, O, "br_in_wait");
            fl = {fl[2:0], last_out[4]};
        end
        check("br_flush_seq", {28'd0, fl}, 32'b0001);

        // Reset in the middle of a memory wait
        run_cycle(st_noack, O, "rw_enter");
        run_cycle(st_noack, O, "rw_wait");
        drive(mkv(5'd5, 5'd5, I, I, I, 5'd5, I, O, I, O, 8'h00));
        #1 rst = 1'b0;
        #1;
        check("rst_mid_outs", {24'd0, dut_out()}, 32'd0);
        check("rst_mid_cnt", hz.stall_cnt, 32'd0);
        check("rst_mid_cnt_sat", {28'd0, hz_s.stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_outs", {24'd0, dut_out()}, 32'd0);
        drive(idle);
        #2 rst = 1'b1;
        m_age = 0;
        m_cnt = 0;
        run_cycle(idle, I, "post_rst_run");
        run_cycle(st_noack, O, "post_rst_wait");
        run_cycle(st_ack, O, "post_rst_ack");

        // Randomized traffic, alternating easy and stingy memory acknowledge
        for (int i = 0; i < 3000; i++) begin
            int thresh;
            thresh = ((i / 400) % 2 == 1) ? 8 : 75;
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.br  = ($urandom_range(0, 3) == 0);
            v.wr  = 1'($urandom_range(0, 1));
            v.ld  = ($urandom_range(0, 2) == 0);
            v.st  = !v.ld && ($urandom_range(0, 3) == 0);
            v.ack = ($urandom_range(0, 99) < thresh);
            v.exp = 8'h00;
            run_cycle(v, O, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall, flush and forwarding controller for the 3-stage pipeline (IF → DE → MW).
- Generates the enable and bubble controls for the PC, the IF/DE buffer and the DE→MW control/data buffers.
- Detects load-use hazards and taken-branch squashes.
- Holds the pipeline while a data-memory access in MW waits for acknowledge, with a timeout.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
WAIT_MAX, 15, max consecutive MEM_WAIT cycles before timeout (≥1)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
rs1_DE  in  5  rs1 of instruction in DE
rs2_DE  in  5  rs2 of instruction in DE
rs1_used_DE  in  1  DE instruction reads rs1
rs2_used_DE  in  1  DE instruction reads rs2
br_taken_DE  in  1  branch/jump resolved taken in DE
rd_MW  in  5  destination register of instruction in MW
reg_wrMW  in  1  MW instruction writes register file
rd_enMW  in  1  MW instruction is a load
wr_enMW  in  1  MW instruction is a store
dmem_ack  in  1  data memory completes current access this cycle
en_pc  out  1  PC register enable
en_FD  out  1  IF/DE buffer enable
en_MW  out  1  DE→MW buffer enable (ctrl and data)
flush_FD  out  1  IF/DE buffer loads NOP on next edge
flush_MW  out  1  DE→MW buffer loads bubble (all ctrl zero) on next edge
fwd_a  out  1  select MW ALU result for operand A in DE
fwd_b  out  1  select MW ALU result for operand B in DE
mem_err  out  1  one-cycle pulse on memory timeout
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0, async):
  - state=RUN, wait counter=0, stall_cnt=0, mem_err=0.
  - en_pc, en_FD, en_MW, flush_FD, flush_MW, fwd_a and fwd_b all forced 0 while rst=0.
  - Reset asserted mid-MEM_WAIT abandons the wait; no mem_err pulse is produced.
- Definitions:
  - mem_req = rd_enMW | wr_enMW.
  - ld_use = rd_enMW & reg_wrMW & (rd_MW≠0) & ((rs1_used_DE & rs1_DE==rd_MW) | (rs2_used_DE & rs2_DE==rd_MW)).
- Forwarding (combinational, all states):
  - fwd_a = reg_wrMW & ~rd_enMW & rd_MW≠0 & rs1_used_DE & rs1_DE==rd_MW.
  - fwd_b is the same with rs2.
  - x0 is never forwarded.
- FSM states: RUN, MEM_WAIT, LD_STALL.
- RUN, evaluated in priority order:
  1. mem_req & ~dmem_ack:
     - all enables 0, no flushes.
     - next state MEM_WAIT, wait counter=1.
  2. ld_use:
     - en_pc=0, en_FD=0, en_MW=1, flush_MW=1 (bubble behind load).
     - next state LD_STALL.
  3. br_taken_DE:
     - all enables 1, flush_FD=1.
     - stay RUN; the target is fetched next cycle.
  4. otherwise all enables 1, no flushes.
- MEM_WAIT:
  - dmem_ack=1: all enables 1, next RUN. The branch/ld_use rules of RUN apply to this cycle's DE instruction in the same priority order, excluding rule 1.
  - counter==WAIT_MAX without ack: mem_err=1 for this cycle, enables 1 (access abandoned), next RUN.
  - otherwise: all enables 0, counter increments.
- LD_STALL:
  - Exactly 1 cycle; load data has been written back, so the register file supplies it.
  - Behaves as RUN; ld_use cannot re-fire because MW now holds a bubble.
- Enable precedence:
  - A flush never overrides a 0 enable on the same buffer.
  - When an enable is 0 its flush is forced 0 (a stall dominates a branch; the branch is re-evaluated when the stall releases).
- stall_cnt:
  - +1 on every cycle with en_pc=0 and rst=1.
  - Saturates at all-ones; no wrap.
- Store to a register that is the DE source: no hazard; stores do not assert reg_wrMW.

Test Plan:
1. ALU result forwarding:
   - Stimulus: reg_wrMW=1, rd_enMW=0, rd_MW=5; DE rs1=5 used, rs2=5 unused.
   - Response: fwd_a=1, fwd_b=0; all enables 1.
   - Repeat with rd_MW=0: fwd_a=0.
2. Load-use stall:
   - Stimulus: rd_enMW=1, reg_wrMW=1, rd_MW=7, dmem_ack=1; DE rs2=7 used.
   - Response: one cycle of en_pc=0, en_FD=0, flush_MW=1, then LD_STALL, then RUN with all enables 1.
   - stall_cnt increments by 1.
3. Memory wait:
   - Stimulus: wr_enMW=1 with dmem_ack low for 3 cycles, then high.
   - Response: enables 0 for 3 cycles, all 1 on the ack cycle; stall_cnt=3; mem_err stays 0.
4. Memory timeout:
   - Stimulus: WAIT_MAX=15, rd_enMW=1, dmem_ack held 0.
   - Response: 15 stalled cycles, then a 1-cycle mem_err pulse with enables 1; FSM returns to RUN.
5. Branch during stall:
   - Stimulus: br_taken_DE=1 while MEM_WAIT pending.
   - Response: flush_FD=0 until the ack cycle; flush_FD=1 on the ack cycle only.
6. Reset mid-wait:
   - Stimulus: rst low during MEM_WAIT.
   - Response: all outputs 0 immediately, stall_cnt=0; after rst rises, FSM is in RUN with no mem_err.
